mem_arbiter: RTL

Parametrised arbiter that lets the processor's instruction-fetch port and data port share one single-port, pipelined memory. It replaces the fixed split between instruction memory and data memory at the top level. It grants at most one access per cycle, drives the memory, and tracks in-flight reads so each read result reaches the port that issued it. It also keeps a saturating count of contention cycles.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/rd_tag_pipe.sv | 27 ++
 rtl/mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: read-owner encoding,
// arbitration modes and default widths.
package mem_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_CNT_W  = 16;

  // One in-flight read slot: whether a read was issued and which port gets it.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// DEPTH-stage shift register of read tags; the tail lines up with the
// memory's read data. Cleared asynchronously so in-flight reads are dropped.
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LAT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port pipelined memory between the fetch and data ports:
// one grant per cycle, read results routed back to the issuing port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int PRIO   = PRIO_FIXED,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  contention_cnt
);

  logic             w_contend;
  logic             w_if_gnt;
  logic             w_dm_gnt;
  owner_e           r_last_winner;
  logic [CNT_W-1:0] r_cnt;
  rd_tag_t          w_push_tag;
  rd_tag_t          w_tail_tag;

  assign w_contend = if_req & dm_req;

  // Grants are held low while reset is asserted, even with requests pending.
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (rst) begin
      if (w_contend) begin
        if (PRIO == PRIO_RR && r_last_winner == OWN_DM) w_if_gnt = 1'b1;
        else                                           w_dm_gnt = 1'b1;
      end else begin
        w_if_gnt = if_req;
        w_dm_gnt = dm_req;
      end
    end
  end

  assign if_gnt = w_if_gnt;
  assign dm_gnt = w_dm_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (w_if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // last_winner only moves on contended cycles; the counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_winner <= OWN_DM;
      r_cnt         <= '0;
    end else if (w_contend) begin
      r_last_winner <= w_dm_gnt ? OWN_DM : OWN_IF;
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign contention_cnt = r_cnt;

  always_comb begin
    w_push_tag       = '0;
    w_push_tag.valid = w_if_gnt | (w_dm_gnt & ~dm_we);
    w_push_tag.owner = w_dm_gnt ? OWN_DM : OWN_IF;
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst_n (rst),
    .i_tag (w_push_tag),
    .o_tag (w_tail_tag)
  );

  assign if_valid = w_tail_tag.valid & (w_tail_tag.owner == OWN_IF);
  assign dm_valid = w_tail_tag.valid & (w_tail_tag.owner == OWN_DM);
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

endmodule
